// File: rtl/prga_decrypt.sv
// RC4 keystream generator / decryptor over a pre-scheduled S memory.
// One message byte costs nine cycles; finish pulses once the last byte is written.
module prga_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              finish,
  output logic              msg_valid,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [ADDR_W-1:0] dec_address,
  output logic [7:0]        dec_data,
  output logic              dec_wren,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_I   = 4'd1,
    WAIT_I = 4'd2,
    RD_J   = 4'd3,
    WAIT_J = 4'd4,
    WR_I   = 4'd5,
    WR_J   = 4'd6,
    RD_F   = 4'd7,
    WAIT_F = 4'd8,
    WR_DEC = 4'd9,
    DONE   = 4'd10
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(MSG_LEN - 1);

  state_t            state, state_nxt;
  logic [7:0]        i, j, si, sj, f, c;
  logic [ADDR_W-1:0] k;
  logic [7:0]        dec_byte;
  logic              is_text;

  assign dbg_state = state;
  assign dec_byte  = f ^ c;
  assign is_text   = ((dec_byte >= 8'h61) && (dec_byte <= 8'h7a)) || (dec_byte == 8'h20);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Datapath registers; every update is tied to the state doing the work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i         <= 8'd0;
      j         <= 8'd0;
      k         <= '0;
      si        <= 8'd0;
      sj        <= 8'd0;
      f         <= 8'd0;
      c         <= 8'd0;
      msg_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          i         <= 8'd0;
          j         <= 8'd0;
          k         <= '0;
          msg_valid <= 1'b1;
        end
        RD_I:   i <= i + 8'd1;
        WAIT_I: begin
          si <= s_q;
          j  <= j + s_q;
        end
        WAIT_J: sj <= s_q;
        WAIT_F: begin
          f <= s_q;
          c <= rom_q;
        end
        WR_DEC: begin
          if (!is_text) msg_valid <= 1'b0;
          if (k != LAST_K) k <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    finish      = 1'b0;
    s_address   = 8'd0;
    s_data      = 8'd0;
    s_wren      = 1'b0;
    rom_address = '0;
    dec_address = '0;
    dec_data    = 8'd0;
    dec_wren    = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = RD_I;
      RD_I: begin
        s_address = i + 8'd1;
        state_nxt = WAIT_I;
      end
      WAIT_I: state_nxt = RD_J;
      RD_J: begin
        s_address = j;
        state_nxt = WAIT_J;
      end
      WAIT_J: state_nxt = WR_I;
      WR_I: begin
        s_address = i;
        s_data    = sj;
        s_wren    = 1'b1;
        state_nxt = WR_J;
      end
      WR_J: begin
        s_address = j;
        s_data    = si;
        s_wren    = 1'b1;
        state_nxt = RD_F;
      end
      RD_F: begin
        s_address   = si + sj;
        rom_address = k;
        state_nxt   = WAIT_F;
      end
      WAIT_F: state_nxt = WR_DEC;
      WR_DEC: begin
        dec_address = k;
        dec_data    = dec_byte;
        dec_wren    = 1'b1;
        state_nxt   = (k == LAST_K) ? DONE : RD_I;
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: synchronous S/ROM models, reference RC4 model feeding
// an expected-byte queue, and run-level timing/strobe checks.
module tb_prga_decrypt;

  localparam int MSG_LEN = 32;
  localparam int ADDR_W  = 5;
  localparam int RUN_EDGES = 9 * MSG_LEN;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              finish, msg_valid, s_wren, dec_wren;
  logic [7:0]        s_address, s_data, s_q, rom_q, dec_data;
  logic [ADDR_W-1:0] rom_address, dec_address;
  logic [3:0]        dbg_state;

  prga_decrypt #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .msg_valid(msg_valid),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .rom_address(rom_address), .rom_q(rom_q), .dec_address(dec_address),
    .dec_data(dec_data), .dec_wren(dec_wren), .dbg_state(dbg_state)
  );

  // ---------------- clock / memories ----------------
  always #5 clk = ~clk;

  logic [7:0] s_mem[256];
  logic [7:0] rom[MSG_LEN];
  logic [7:0] dec_mem[MSG_LEN];
  logic [1:0] s_init = 2'd0;  // 1: identity, 2: identity with S[0]/S[1] swapped

  always @(posedge clk) begin
    if (s_init != 2'd0) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
      if (s_init == 2'd2) begin
        s_mem[0] <= 8'd1;
        s_mem[1] <= 8'd0;
      end
    end else if (s_wren) begin
      s_mem[s_address] <= s_data;
    end
    s_q   <= s_mem[s_address];
    rom_q <= rom[rom_address];
  end

  // ---------------- scoreboard / counters ----------------
  int total = 0;
  int bad   = 0;
  logic [ADDR_W+7:0] exp_q[$];
  logic              exp_valid;
  int s_cnt, d_cnt, both_cnt, x_cnt;

  logic [7:0] model_s[256];
  logic [7:0] tmp_s[256];
  logic [7:0] ks[MSG_LEN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if ($isunknown({finish, msg_valid, s_address, s_data, s_wren, rom_address,
                      dec_address, dec_data, dec_wren})) x_cnt++;
      if (s_wren) s_cnt++;
      if (dec_wren) d_cnt++;
      if (s_wren && dec_wren) both_cnt++;
      if (dec_wren) begin
        dec_mem[dec_address] = dec_data;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL sb_unexpected: observed=%0h expected=none", {dec_address, dec_data});
        end else begin
          chk("dec_byte", 32'({dec_address, dec_data}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic gen_ks();
    logic [7:0] mi, mj, t;
    mi = 8'd0;
    mj = 8'd0;
    for (int n = 0; n < MSG_LEN; n++) begin
      mi = mi + 8'd1;
      mj = mj + model_s[mi];
      t = model_s[mi];
      model_s[mi] = model_s[mj];
      model_s[mj] = t;
      t = model_s[mi] + model_s[mj];
      ks[n] = model_s[t];
    end
  endtask

  task automatic push_run();
    logic [7:0] d;
    gen_ks();
    exp_valid = 1'b1;
    for (int n = 0; n < MSG_LEN; n++) begin
      d = ks[n] ^ rom[n];
      exp_q.push_back({ADDR_W'(n), d});
      if (!(((d >= 8'h61) && (d <= 8'h7a)) || (d == 8'h20))) exp_valid = 1'b0;
    end
  endtask

  task automatic model_identity(input logic swap01);
    for (int x = 0; x < 256; x++) model_s[x] = 8'(x);
    if (swap01) begin
      model_s[0] = 8'd1;
      model_s[1] = 8'd0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_s(input logic [1:0] mode);
    s_init = mode;
    @(posedge clk);
    #1 s_init = 2'd0;
  endtask

  task automatic clear_counts();
    s_cnt = 0;
    d_cnt = 0;
    both_cnt = 0;
  endtask

  // Waits (bounded) for finish; returns rising edges seen since the call.
  task automatic wait_finish(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (!finish && edges < 2 * RUN_EDGES);
  endtask

  task automatic run_one(input string tag);
    int edges;
    clear_counts();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_finish(edges);
    chk({tag, "_finish_cycle"}, 32'(edges), 32'(RUN_EDGES));
    chk({tag, "_msg_valid"}, 32'(msg_valid), 32'(exp_valid));
    @(negedge clk);
    chk({tag, "_finish_width"}, 32'(finish), 32'd0);
    chk({tag, "_valid_hold"}, 32'(msg_valid), 32'(exp_valid));
    chk({tag, "_s_wren_cnt"}, 32'(s_cnt), 32'(2 * MSG_LEN));
    chk({tag, "_dec_wren_cnt"}, 32'(d_cnt), 32'(MSG_LEN));
    chk({tag, "_both_wren"}, 32'(both_cnt), 32'd0);
    chk({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk(tag, 32'({finish, msg_valid, s_address, s_data, s_wren, rom_address,
                  dec_address, dec_data, dec_wren}), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int edges;
    int dups;
    logic [255:0] seen;
    rst = 1'b0;
    start = 1'b0;
    x_cnt = 0;
    clear_counts();
    for (int n = 0; n < MSG_LEN; n++) rom[n] = 8'h00;
    #12;
    chk_outputs_zero("reset_outputs");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Identity S, zero ROM: output is the raw keystream.
    load_s(2'd1);
    model_identity(1'b0);
    push_run();
    run_one("ident_zero");
    chk("dec0", 32'(dec_mem[0]), 32'h02);
    chk("dec1", 32'(dec_mem[1]), 32'h05);
    chk("ident_zero_valid0", 32'(msg_valid), 32'd0);

    // ROM pre-masked so every byte decrypts to 'a'.
    load_s(2'd1);
    model_identity(1'b0);
    for (int x = 0; x < 256; x++) tmp_s[x] = model_s[x];
    gen_ks();
    for (int n = 0; n < MSG_LEN; n++) rom[n] = 8'h61 ^ ks[n];
    for (int x = 0; x < 256; x++) model_s[x] = tmp_s[x];
    push_run();
    run_one("all_a");
    chk("all_a_valid1", 32'(msg_valid), 32'd1);
    dups = 0;
    for (int n = 0; n < MSG_LEN; n++) if (dec_mem[n] !== 8'h61) dups++;
    chk("all_a_bytes", 32'(dups), 32'd0);

    // S[1]=0: first j stays 0, later i==j swaps become possible.
    load_s(2'd2);
    model_identity(1'b1);
    for (int n = 0; n < MSG_LEN; n++) rom[n] = 8'($urandom_range(0, 255));
    x_cnt = 0;
    push_run();
    run_one("s1_zero");
    chk("s1_zero_no_x", 32'(x_cnt), 32'd0);
    seen = '0;
    dups = 0;
    for (int x = 0; x < 256; x++) begin
      if (seen[s_mem[x]]) dups++;
      seen[s_mem[x]] = 1'b1;
      if (s_mem[x] !== model_s[x]) dups++;
    end
    chk("s1_zero_perm", 32'(dups), 32'd0);

    // start held high: back-to-back runs on the evolving S.
    clear_counts();
    push_run();
    push_run();
    start = 1'b1;
    @(posedge clk);
    wait_finish(edges);
    chk("b2b_first_finish", 32'(edges), 32'(RUN_EDGES));
    @(negedge clk);
    chk("b2b_idle_gap", 32'(dbg_state), 32'd0);
    @(negedge clk);
    chk("b2b_rd_i", 32'(dbg_state), 32'd1);
    wait_finish(edges);
    #1 start = 1'b0;
    chk("b2b_second_finish", 32'(edges + 2), 32'(RUN_EDGES + 2));
    chk("b2b_msg_valid", 32'(msg_valid), 32'(exp_valid));
    chk("b2b_s_wren_cnt", 32'(s_cnt), 32'(4 * MSG_LEN));
    chk("b2b_dec_wren_cnt", 32'(d_cnt), 32'(2 * MSG_LEN));
    chk("b2b_both_wren", 32'(both_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_stopped", 32'(dbg_state), 32'd0);
    chk("b2b_sb_drained", 32'(exp_q.size()), 32'd0);

    // Abort mid-run with reset, then a clean full run.
    push_run();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_outputs_zero("abort_outputs");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'(dbg_state), 32'd0);
    for (int x = 0; x < 256; x++) model_s[x] = s_mem[x];
    push_run();
    run_one("after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prga_decrypt.md
PRGA_DECRYPT -- requirements
Module: prga_decrypt

Interface
REQ-001 Parameter MSG_LEN, default 32, gives the number of message bytes decrypted per run, with a legal range of 1..32.
REQ-002 Parameter ADDR_W, default 5, gives the width of the ROM and result-memory address.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to begin decryption, sampled in IDLE only.
REQ-006 Port finish, output, 1 bit: one-cycle pulse marking run complete.
REQ-007 Port msg_valid, output, 1 bit: high when every decrypted byte of the last run is 0x61..0x7A or 0x20.
REQ-008 Port s_address, output, 8 bits: S (working) memory address.
REQ-009 Port s_data, output, 8 bits: S memory write data.
REQ-010 Port s_wren, output, 1 bit: S memory write enable.
REQ-011 Port s_q, input, 8 bits: S memory read data, valid one cycle after the address is driven.
REQ-012 Port rom_address, output, ADDR_W bits: encrypted-message ROM address.
REQ-013 Port rom_q, input, 8 bits: ROM read data, one-cycle latency.
REQ-014 Port dec_address, output, ADDR_W bits: decrypted-message memory address.
REQ-015 Port dec_data, output, 8 bits: decrypted byte.
REQ-016 Port dec_wren, output, 1 bit: decrypted-memory write enable.

Function
REQ-017 The block SHALL implement the RC4 PRGA over an already-scheduled S memory: for k = 0..MSG_LEN-1, i=i+1; j=j+S[i]; swap S[i],S[j]; f=S[(S[i]+S[j]) mod 256]; dec[k]=f XOR rom[k].
REQ-018 i, j and the index sum SHALL be 8-bit and wrap modulo 256; k SHALL count 0..MSG_LEN-1 with no wrap.
REQ-019 The states SHALL be IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, RD_F, WAIT_F, WR_DEC and DONE.
REQ-020 IDLE: when start=1, clear i, j and k, set msg_valid=1, and go to RD_I; otherwise remain in IDLE.
REQ-021 RD_I: drive s_address=i+1 and register i<=i+1.
REQ-022 WAIT_I: latch si<=s_q and j<=j+s_q.
REQ-023 RD_J: drive s_address=j.
REQ-024 WAIT_J: latch sj<=s_q.
REQ-025 WR_I: drive s_address=i, s_data=sj, s_wren=1.
REQ-026 WR_J: drive s_address=j, s_data=si, s_wren=1.
REQ-027 RD_F: drive s_address=si+sj (8-bit) and rom_address=k.
REQ-028 WAIT_F: latch f<=s_q and c<=rom_q.
REQ-029 WR_DEC: drive dec_address=k, dec_data=f^c, dec_wren=1; clear msg_valid if f^c is not a lowercase letter or space; if k=MSG_LEN-1 go to DONE, else k<=k+1 and go to RD_I.
REQ-030 DONE: finish=1 for exactly one cycle, then go to IDLE.
REQ-031 Each byte SHALL take exactly 9 cycles, so finish is high in the cycle after the 9*MSG_LEN-th rising edge following the edge that sampled start (cycle 289 for the default).
REQ-032 s_wren and dec_wren SHALL be 0 in every state except WR_I/WR_J and WR_DEC respectively.
REQ-033 When i=j, the WR_I and WR_J writes SHALL still both occur, with the same data, and leave S unchanged.
REQ-034 start asserted outside IDLE SHALL be ignored; start held high through DONE SHALL begin a new run on the first IDLE cycle.
REQ-035 msg_valid SHALL hold its final value after finish until the next run starts.
REQ-036 Addresses and data outputs SHALL be 0 in states that do not drive them.

Reset
REQ-037 rst=0 SHALL immediately force IDLE, zero i, j, k, si, sj, f, c, zero every output including msg_valid, and abort any run; partially swapped S contents are not restored.
REQ-038 After rst deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-039 S[x]=x, ROM all 0x00, start pulse -> dec[0]=0x02, dec[1]=0x05, finish at cycle 289, msg_valid=0.
REQ-040 Same S, ROM[k]=0x61 XOR the expected keystream[k] -> every dec[k]=0x61 and msg_valid=1 at finish.
REQ-041 Bench monitor on all runs -> s_wren high exactly 2 cycles per byte, dec_wren exactly 1, and never both high in one cycle.
REQ-042 S[1]=0x00 (forces j=0, then i=j cases later) -> no X on outputs and S remains a permutation after the run.
REQ-043 rst pulled low at cycle 100 of a run -> all outputs 0 the same cycle; a new start afterwards produces a full 289-cycle run.
REQ-044 start held high continuously -> back-to-back runs with exactly one IDLE cycle between DONE and the next RD_I.
